display_request_arbiter: RTL and testbench
==========================================

// Module: display_request_arbiter
// PURPOSE
//  Shares the 5-digit seven-segment display among NUM_REQ producer processes.
//  Round-robin arbiter with a valid/ready handshake per requester.
//  Converts the granted binary value to 5 BCD digits with a sequential double-dabble.
//  Drives digit_4..digit_0 into the existing per-digit hex decoders.
//  Holds each shown value for HOLD_CYCLES before the next grant.
// PARAMETERS
//  NUM_REQ      4     number of requesters, 2..8
//  DATA_W       16    requester value width; max 65535 fits 5 decimal digits; legal range 1..16
//  HOLD_CYCLES  1000  minimum cycles a value stays displayed; 0 = no hold
//  SRC_W        3     width of disp_src; must be >= clog2(NUM_REQ)
// PORTS
//  clk          in   1                  single clock, rising edge
//  reset_n      in   1                  asynchronous active-low reset
//  req_valid    in   NUM_REQ            requester i has a value pending
//  req_data     in   NUM_REQ*DATA_W     requester i value at [i*DATA_W +: DATA_W]
//  req_ready    out  NUM_REQ            one-hot accept; transfer = valid & ready
//  digit_4      out  4                  BCD ten-thousands
//  digit_3      out  4                  BCD thousands
//  digit_2      out  4                  BCD hundreds
//  digit_1      out  4                  BCD tens
//  digit_0      out  4                  BCD units
//  disp_src     out  SRC_W              index of requester currently displayed
//  disp_update  out  1                  1-cycle pulse when digits change
//  busy         out  1                  high in every state except IDLE
// BEHAVIOUR
//  Reset, async on reset_n low:
//   - digits=0, disp_src=0, disp_update=0, req_ready=0, busy=0.
//   - state=IDLE; rr pointer=0, so req 0 has top priority after reset.
//  FSM: IDLE -> CONVERT -> LOAD -> HOLD -> IDLE.
//  IDLE:
//   - If any req_valid, req_ready is asserted combinationally, one-hot.
//   - The ready bit goes to the first valid index at or after the rr pointer, wrapping NUM_REQ-1 -> 0.
//   - Transfer happens at that clock edge: data and grant index are latched, rr pointer = grant+1 (mod NUM_REQ).
//   - Next state is CONVERT.
//   - req_ready=0 in every other state.
//  CONVERT:
//   - Exactly DATA_W cycles of double-dabble.
//   - Each cycle: add 3 to every BCD nibble >= 5, then shift the 20-bit BCD register and data MSB left by 1.
//   - Internal registers only; outputs are unchanged.
//  LOAD (1 cycle):
//   - digit_4..0 and disp_src take the new values at the exit edge.
//   - disp_update=1 during the following cycle only.
//   - Latency: transfer edge -> digits visible = DATA_W+1 cycles.
//  HOLD:
//   - Counter runs HOLD_CYCLES cycles, then IDLE.
//   - If HOLD_CYCLES=0, LOAD goes directly to IDLE.
//  Output formatting:
//   - Leading zeros are shown (no blanking).
//   - Values narrower than 16 bits are zero-extended.
//  Simultaneous valids: served strictly in rotation; no requester waits more than NUM_REQ grants.
//  Requester protocol:
//   - A requester may drop req_valid before it is granted; no transfer happens then.
//   - req_data is sampled only at the transfer edge.
//  Reset mid-operation (any state): conversion is aborted, no disp_update, digits return to 0.
// TESTING (NUM_REQ=4, DATA_W=16, HOLD_CYCLES=4)
//  1. Release reset, no valids -> all digits 0, req_ready=0, busy=0, disp_update never pulses.
//  2. req_valid=0001, data0=12345
//     -> req_ready=0001 in the first cycle.
//     -> 17 cycles later digits=1,2,3,4,5, disp_src=0, one disp_update pulse.
//     -> busy low again 4 cycles after LOAD.
//  3. data0=65535, then data0=0 -> digits 6,5,5,3,5, then 0,0,0,0,0; the second value also pulses disp_update.
//  4. req_valid=1111 held, data i=100*(i+1)
//     -> grants 0,1,2,3,0 in order.
//     -> displays 00100, 00200, 00300, 00400.
//     -> successive disp_update pulses are 1+16+1+4 = 22 cycles apart.
//  5. Grant req 2 (data=999), assert reset_n=0 at CONVERT cycle 8
//     -> digits stay/return 0, no disp_update.
//     -> after release with req_valid=0110, req 1 is granted first.
//  6. HOLD_CYCLES=0, req_valid=0011 held -> back-to-back grants 0,1,0.
//     -> disp_update pulses every 18 cycles.
//     -> req_ready is never asserted outside IDLE.

Source files
------------

// File: rtl/display_request_arbiter.sv
// display_request_arbiter: round-robin share of a 5-digit BCD display among NUM_REQ producers
//  clk, reset_n        rising-edge clock, asynchronous active-low reset
//  req_valid/req_data  per-requester offers; value i at req_data[i*DATA_W +: DATA_W]
//  req_ready           one-hot accept, only while idle; transfer = valid & ready
//  digit_4..digit_0    BCD digits of the displayed value, leading zeros kept
//  disp_src            index of the requester whose value is displayed
//  disp_update         one-cycle pulse after the digits change
//  busy                high while a value is being converted, loaded or held
module display_request_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 16,
  parameter int HOLD_CYCLES = 1000,
  parameter int SRC_W       = 3
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [3:0]                digit_4,
  output logic [3:0]                digit_3,
  output logic [3:0]                digit_2,
  output logic [3:0]                digit_1,
  output logic [3:0]                digit_0,
  output logic [SRC_W-1:0]          disp_src,
  output logic                      disp_update,
  output logic                      busy
);
  localparam int CNT_MAX = HOLD_CYCLES > DATA_W ? HOLD_CYCLES : DATA_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  typedef enum logic [1:0] {IDLE, CONVERT, LOAD, HOLD} state_e;
  state_e             state_q, state_d;
  logic [SRC_W-1:0]   ptr_q, ptr_d, src_q, src_d, out_src_q, out_src_d, gnt_idx;
  logic [NUM_REQ-1:0] lo_mask, hi, pick, gnt;
  logic [DATA_W-1:0]  data_q, data_d, gnt_data;
  logic [19:0]        bcd_q, bcd_d, adj, digits_q, digits_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               upd_q, upd_d;
  // Requests at or above the pointer win; if none, wrap to the lowest valid index.
  assign lo_mask = (NUM_REQ'(1) << ptr_q) - NUM_REQ'(1);
  assign hi      = req_valid & ~lo_mask;
  assign pick    = |hi ? hi : req_valid;
  assign gnt     = pick & (~pick + NUM_REQ'(1));
  always_comb begin
    gnt_idx  = '0;
    gnt_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) begin
        gnt_idx  = SRC_W'(i);
        gnt_data = req_data[i*DATA_W +: DATA_W];
      end
  end
  // Double-dabble correction: every BCD nibble of 5 or more gets +3 before the shift.
  genvar n;
  for (n = 0; n < 5; n++) begin : g_adj
    assign adj[4*n +: 4] = bcd_q[4*n +: 4] >= 4'd5 ? bcd_q[4*n +: 4] + 4'd3 : bcd_q[4*n +: 4];
  end
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    src_d     = src_q;
    out_src_d = out_src_q;
    data_d    = data_q;
    bcd_d     = bcd_q;
    digits_d  = digits_q;
    cnt_d     = cnt_q;
    upd_d     = 1'b0;
    case (state_q)
      IDLE: if (|req_valid) begin
        state_d = CONVERT;
        ptr_d   = gnt_idx == SRC_W'(NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
        src_d   = gnt_idx;
        data_d  = gnt_data;
        bcd_d   = '0;
        cnt_d   = '0;
      end
      CONVERT: begin
        bcd_d  = 20'({adj, data_q[DATA_W-1]});
        data_d = data_q << 1;
        cnt_d  = cnt_q + 1'b1;
        state_d = cnt_q == CNT_W'(DATA_W - 1) ? LOAD : CONVERT;
      end
      LOAD: begin
        digits_d  = bcd_q;
        out_src_d = src_q;
        upd_d     = 1'b1;
        cnt_d     = '0;
        state_d   = HOLD_CYCLES == 0 ? IDLE : HOLD;
      end
      default: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_q == CNT_W'(HOLD_CYCLES - 1) ? IDLE : HOLD;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      src_q     <= '0;
      out_src_q <= '0;
      data_q    <= '0;
      bcd_q     <= '0;
      digits_q  <= '0;
      cnt_q     <= '0;
      upd_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      src_q     <= src_d;
      out_src_q <= out_src_d;
      data_q    <= data_d;
      bcd_q     <= bcd_d;
      digits_q  <= digits_d;
      cnt_q     <= cnt_d;
      upd_q     <= upd_d;
    end
  // Gated by reset_n so no accept is offered while reset is held.
  assign req_ready   = state_q == IDLE && reset_n ? gnt : '0;
  assign digit_4     = digits_q[19:16];
  assign digit_3     = digits_q[15:12];
  assign digit_2     = digits_q[11:8];
  assign digit_1     = digits_q[7:4];
  assign digit_0     = digits_q[3:0];
  assign disp_src    = out_src_q;
  assign disp_update = upd_q;
  assign busy        = state_q != IDLE;
endmodule

// File: tb/tb_display_request_arbiter.sv
// tb_display_request_arbiter: table, directed and random checks of display_request_arbiter
module tb_display_request_arbiter;
  localparam int N = 4, W = 16, H = 4, SW = 3;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [N-1:0] req_valid = '0, z_valid = '0, req_ready, z_ready;
  logic [N*W-1:0] req_data = '0, z_data = '0;
  logic [3:0] d4, d3, d2, d1, d0, z4, z3, z2, z1, z0;
  logic [SW-1:0] disp_src, z_src;
  logic disp_update, busy, z_update, z_busy;
  always #5 clk = ~clk;
  display_request_arbiter #(.NUM_REQ(N), .DATA_W(W), .HOLD_CYCLES(H), .SRC_W(SW)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .digit_4(d4), .digit_3(d3), .digit_2(d2), .digit_1(d1), .digit_0(d0),
    .disp_src(disp_src), .disp_update(disp_update), .busy(busy));
  display_request_arbiter #(.NUM_REQ(N), .DATA_W(W), .HOLD_CYCLES(0), .SRC_W(SW)) dut0 (
    .clk(clk), .reset_n(reset_n), .req_valid(z_valid), .req_data(z_data), .req_ready(z_ready),
    .digit_4(z4), .digit_3(z3), .digit_2(z2), .digit_1(z1), .digit_0(z0),
    .disp_src(z_src), .disp_update(z_update), .busy(z_busy));
  typedef struct {
    logic [N-1:0]   valid;
    logic [N*W-1:0] data;
    int             grant;
    logic [19:0]    digits;
  } vec_t;
  vec_t tbl[7];
  int tests = 0, fails = 0;
  int m_ptr, m_left, m_load, m_val, m_src, m_pval, m_psrc, m_upd;
  int cyc_n = 0, last_g, n_upd;
  int gq[$], ut[$], zg[$], zu[$];
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask
  function automatic int pick(logic [N-1:0] v, int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  function automatic logic [19:0] to_bcd(int v);
    logic [19:0] r;
    for (int k = 0; k < 5; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction
  task automatic model_reset();
    m_ptr = 0; m_left = 0; m_load = 0; m_val = 0; m_src = 0; m_upd = 0;
  endtask
  task automatic cyc();
    int g;
    #1;
    g = m_left == 0 ? pick(req_valid, m_ptr) : -1;
    check("ready", 32'(req_ready), g < 0 ? 0 : 1 << g);
    check("busy", 32'(busy), 32'(m_left != 0));
    check("digits", {d4, d3, d2, d1, d0}, to_bcd(m_val));
    check("src", 32'(disp_src), m_src);
    check("update", 32'(disp_update), m_upd);
    for (int i = 0; i < N; i++)
      if (req_ready[i]) begin
        last_g = i;
        gq.push_back(i);
      end
    if (disp_update) begin
      n_upd++;
      ut.push_back(cyc_n);
    end
    @(posedge clk);
    cyc_n++;
    m_upd = 0;
    if (g >= 0) begin
      m_ptr = (g + 1) % N; m_pval = int'(req_data[g*W +: W]); m_psrc = g;
      m_left = W + 1 + H; m_load = W + 1;
    end else if (m_left > 0) begin
      m_left--; m_load--;
      if (m_load == 0) begin
        m_val = m_pval; m_src = m_psrc; m_upd = 1;
      end
    end
    @(negedge clk);
  endtask
  task automatic check_reset_outputs(string tag);
    check({tag, "_digits"}, {d4, d3, d2, d1, d0}, 0);
    check({tag, "_ready"}, 32'(req_ready), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_update"}, 32'(disp_update), 0);
    check({tag, "_src"}, 32'(disp_src), 0);
  endtask
  initial begin
    tbl[0] = '{4'b0001, {48'd0, 16'd12345}, 0, 20'h12345};
    tbl[1] = '{4'b0001, {48'd0, 16'd65535}, 0, 20'h65535};
    tbl[2] = '{4'b0001, 64'd0, 0, 20'h00000};
    tbl[3] = '{4'b1000, {16'd7, 48'd0}, 3, 20'h00007};
    tbl[4] = '{4'b0110, {16'd0, 16'd99, 16'd42, 16'd0}, 1, 20'h00042};
    tbl[5] = '{4'b0110, {16'd0, 16'd99, 16'd42, 16'd0}, 2, 20'h00099};
    tbl[6] = '{4'b1001, {16'd1, 32'd0, 16'd50000}, 3, 20'h00001};
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    reset_n = 1'b1;
    repeat (6) cyc();
    for (int v = 0; v < 7; v++) begin
      req_valid = tbl[v].valid; req_data = tbl[v].data; last_g = -1; n_upd = 0;
      cyc();
      req_valid = '0;
      repeat (W + 1 + H) cyc();
      check("tbl_grant", last_g, tbl[v].grant);
      check("tbl_digits", {d4, d3, d2, d1, d0}, tbl[v].digits);
      check("tbl_upd_count", n_upd, 1);
    end
    gq.delete(); ut.delete();
    req_valid = 4'b1111; req_data = {16'd400, 16'd300, 16'd200, 16'd100};
    repeat (4 * 22 + 2) cyc();
    req_valid = '0;
    repeat (22) cyc();
    for (int k = 0; k < 5; k++) check("rr_grant", k < gq.size() ? gq[k] : -1, k % 4);
    for (int k = 1; k < 4; k++) check("rr_spacing", k < ut.size() ? ut[k] - ut[k-1] : -1, 22);
    req_valid = 4'b0100; req_data = {16'd0, 16'd999, 32'd0}; last_g = -1;
    cyc();
    check("t5_grant", last_g, 2);
    req_valid = '0;
    repeat (8) cyc();
    reset_n = 1'b0; req_valid = 4'b0110;
    #1 check_reset_outputs("midrst");
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midrst_hold");
    model_reset();
    reset_n = 1'b1; gq.delete(); n_upd = 0;
    repeat (W + 1 + H + 1) cyc();
    check("t5_first_grant", gq.size() > 0 ? gq[0] : -1, 1);
    req_valid = '0;
    repeat (22) cyc();
    repeat (400) begin
      if ($urandom_range(3) == 0) req_valid = N'($urandom);
      if ($urandom_range(1) == 1) req_data = {$urandom, $urandom};
      cyc();
    end
    req_valid = '0;
    repeat (25) cyc();
    z_valid = 4'b0011; z_data = {32'd0, 16'd22, 16'd11};
    for (int c = 0; c < 60; c++) begin
      #1;
      if (z_ready != 0) begin
        check("z_ready_idle", 32'(z_busy), 0);
        for (int i = 0; i < N; i++) if (z_ready[i]) zg.push_back(i);
      end
      if (z_update) zu.push_back(c);
      @(posedge clk);
      @(negedge clk);
    end
    z_valid = '0;
    repeat (20) @(negedge clk);
    for (int k = 0; k < 3; k++) check("z_grant", k < zg.size() ? zg[k] : -1, k % 2);
    for (int k = 1; k < 3; k++) check("z_spacing", k < zu.size() ? zu[k] - zu[k-1] : -1, 18);
    check("z_digits", {z4, z3, z2, z1, z0}, 20'h00022);
    check("z_src", 32'(z_src), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
